// File: rtl/mwadd_pkg.sv
// mwadd_pkg: shared FSM state type and default geometry for the multi-word adder sequencer.
package mwadd_pkg;
  localparam int CHUNK_W = 64;
  localparam int N_CHUNKS_DEF = 4;
  localparam int HOLD_DEF = 2;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/mwadd_chunk_ctr.sv
// mwadd_chunk_ctr: chunk index k and hold-phase counter c for the sequencer.
module mwadd_chunk_ctr
  import mwadd_pkg::*;
#(
  parameter int N_CHUNKS = N_CHUNKS_DEF,
  parameter int HOLD = HOLD_DEF,
  parameter int KW = 2,
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [KW-1:0] k,
  output logic [CW-1:0] c,
  output logic          last_phase,
  output logic          last_chunk
);
  logic [KW-1:0] k_q, k_d;
  logic [CW-1:0] c_q, c_d;
  always_comb begin
    k_d = clr ? '0 : (en && last_phase) ? k_q + KW'(1) : k_q;
    c_d = (clr || (en && last_phase)) ? '0 : en ? c_q + CW'(1) : c_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q <= '0;
      c_q <= '0;
    end else begin
      k_q <= k_d;
      c_q <= c_d;
    end
  end
  assign k = k_q;
  assign c = c_q;
  assign last_phase = c_q == CW'(HOLD);
  assign last_chunk = k_q == KW'(N_CHUNKS - 1);
endmodule

// File: rtl/mwadd_seq.sv
// mwadd_seq: sequences a wide add through an external registered 64-bit adder, one chunk per HOLD+1 cycles.
// Define MWADD_SUB_EN to add the op_sub input (a - b via inverted b and forced carry-in).
module mwadd_seq
  import mwadd_pkg::*;
#(
  parameter int N_CHUNKS = N_CHUNKS_DEF,
  parameter int HOLD = HOLD_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CHUNK_W*N_CHUNKS-1:0]   op_a,
  input  logic [CHUNK_W*N_CHUNKS-1:0]   op_b,
  input  logic                          op_cin,
`ifdef MWADD_SUB_EN
  input  logic                          op_sub,
`endif
  output logic [CHUNK_W-1:0]            add_a,
  output logic [CHUNK_W-1:0]            add_b,
  output logic                          add_cin,
  input  logic [CHUNK_W-1:0]            add_sum,
  input  logic                          add_cout,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CHUNK_W*N_CHUNKS-1:0]   out_sum,
  output logic                          out_cout
);
  localparam int W = CHUNK_W * N_CHUNKS;
  localparam int KW = N_CHUNKS > 1 ? $clog2(N_CHUNKS) : 1;
  localparam int CW = HOLD > 0 ? $clog2(HOLD + 1) : 1;
  state_e state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic cin_q, cin_d, sub_q, sub_d, carry_q, carry_d, cout_q, cout_d;
  logic [KW-1:0] k;
  logic [CW-1:0] c;
  logic last_phase, last_chunk, accept, run, capture;
  assign accept = in_valid && state_q == IDLE;
  assign run = state_q == RUN;
  assign capture = run && last_phase && c == CW'(HOLD);
  mwadd_chunk_ctr #(.N_CHUNKS(N_CHUNKS), .HOLD(HOLD), .KW(KW), .CW(CW)) u_ctr (
    .clk(clk), .rst(rst), .clr(accept), .en(run),
    .k(k), .c(c), .last_phase(last_phase), .last_chunk(last_chunk)
  );
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    cin_d = cin_q;
    sub_d = sub_q;
    sum_d = sum_q;
    carry_d = carry_q;
    cout_d = cout_q;
    if (accept) begin
      state_d = RUN;
      a_d = op_a;
      b_d = op_b;
      cin_d = op_cin;
`ifdef MWADD_SUB_EN
      sub_d = op_sub;
`endif
    end
    if (capture) begin
      sum_d[k*CHUNK_W +: CHUNK_W] = add_sum;
      carry_d = add_cout;
      if (last_chunk) begin
        cout_d = add_cout;
        state_d = DONE;
      end
    end
    if (state_q == DONE && out_ready) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      cin_q <= 1'b0;
      sub_q <= 1'b0;
      sum_q <= '0;
      carry_q <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      cin_q <= cin_d;
      sub_q <= sub_d;
      sum_q <= sum_d;
      carry_q <= carry_d;
      cout_q <= cout_d;
    end
  end
  // chunk 0 takes the wide carry-in (forced to 1 when subtracting), later chunks the previous carry
  assign add_a = run ? a_q[k*CHUNK_W +: CHUNK_W] : '0;
  assign add_b = run ? b_q[k*CHUNK_W +: CHUNK_W] ^ {CHUNK_W{sub_q}} : '0;
  assign add_cin = run ? (k == '0 ? (cin_q | sub_q) : carry_q) : 1'b0;
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out_sum = sum_q;
  assign out_cout = cout_q;
endmodule

// File: tb/tb_mwadd_seq.sv
// tb_mwadd_seq: directed and random checks of mwadd_seq against a HOLD-deep registered adder model.
module tb_mwadd_seq;
  localparam int N = 4;
  localparam int HOLD = 2;
  localparam int W = 64 * N;
  localparam int LAT = N * (HOLD + 1);
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, op_cin = 1'b0, op_sub = 1'b0, out_ready = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic in_ready, add_cin, add_cout, out_valid, out_cout;
  logic [63:0] add_a, add_b, add_sum;
  logic [W-1:0] out_sum;
  logic [64:0] pipe [HOLD];
  int checks = 0, failures = 0;

  mwadd_seq #(.N_CHUNKS(N), .HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
`ifdef MWADD_SUB_EN
    .op_sub(op_sub),
`endif
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + 65'(add_cin);
    for (int i = 1; i < HOLD; i++) pipe[i] <= pipe[i-1];
  end
  assign {add_cout, add_sum} = pipe[HOLD-1];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd;
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic s,
                        output logic [W:0] res, output int lat);
    op_a = a;
    op_b = b;
    op_cin = cin;
    op_sub = s;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      tick;
      lat++;
    end
    if (out_valid !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL do_add_timeout out_valid=%b after %0d cycles required 1", out_valid, lat);
    end
    res = {out_cout, out_sum};
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL reset_hs in_ready,out_valid=%b required 10", {in_ready, out_valid});
    end
    checks++;
    if ({add_a, add_b, add_cin} !== '0) begin
      failures++;
      $display("FAIL reset_add add_a=%h add_b=%h add_cin=%b required 0", add_a, add_b, add_cin);
    end
    checks++;
    if ({out_cout, out_sum} !== '0) begin
      failures++;
      $display("FAIL reset_out out_sum=%h out_cout=%b required 0", out_sum, out_cout);
    end
    tick;
    tick;
    rst = 1'b0;
    tick;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_all_ones;
    logic [W:0] res;
    int lat;
    do_add('1, W'(1), 1'b0, 1'b0, res, lat);
    checks++;
    if (res !== {1'b1, {W{1'b0}}}) begin
      failures++;
      $display("FAIL all_ones got=%h required=%h", res, {1'b1, {W{1'b0}}});
    end
    checks++;
    if (lat != LAT) begin
      failures++;
      $display("FAIL all_ones_latency got=%0d required=%0d", lat, LAT);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL done_in_ready got=%b required 0", in_ready);
    end
    release_out;
  endtask

  task automatic test_ripple;
    logic [W-1:0] va, vb;
    logic ok_cin, ok_ops;
    int ch;
    va = {128'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF};
    vb = W'(1);
    op_a = va;
    op_b = vb;
    op_cin = 1'b0;
    op_sub = 1'b0;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    ok_cin = 1'b1;
    ok_ops = 1'b1;
    for (int cyc = 0; cyc < LAT; cyc++) begin
      ch = cyc / (HOLD + 1);
      if (add_cin !== (ch == 1)) ok_cin = 1'b0;
      if (add_a !== va[ch*64 +: 64] || add_b !== vb[ch*64 +: 64]) ok_ops = 1'b0;
      tick;
    end
    checks++;
    if (!ok_cin) begin
      failures++;
      $display("FAIL ripple_cin add_cin pattern wrong last add_cin=%b required 1 only in chunk 1", add_cin);
    end
    checks++;
    if (!ok_ops) begin
      failures++;
      $display("FAIL ripple_ops chunk operands not held per chunk last add_a=%h add_b=%h", add_a, add_b);
    end
    checks++;
    if (out_valid !== 1'b1 || {out_cout, out_sum} !== {1'b0, 128'h0, 64'h2, 64'h0}) begin
      failures++;
      $display("FAIL ripple_sum out_valid=%b got=%h required=%h", out_valid, {out_cout, out_sum},
               {1'b0, 128'h0, 64'h2, 64'h0});
    end
    release_out;
  endtask

  task automatic test_stall;
    logic [W:0] res, exp;
    int lat;
    logic ok;
    exp = {1'b0, {3{64'h1234_5678_9ABC_DF00}}, 64'h1234_5678_9ABC_DF01};
    do_add({4{64'h0123_4567_89AB_CDEF}}, {4{64'h1111_1111_1111_1111}}, 1'b1, 1'b0, res, lat);
    checks++;
    if (res !== exp) begin
      failures++;
      $display("FAIL stall_sum got=%h required=%h", res, exp);
    end
    op_a = '1;
    in_valid = 1'b1;
    ok = 1'b1;
    repeat (5) begin
      tick;
      if ({out_cout, out_sum} !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL stall_hold out_sum=%h in_ready=%b out_valid=%b required stable/0/1", out_sum, in_ready, out_valid);
    end
    out_ready = 1'b1;
    tick;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_release in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL release_no_accept in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_reset_mid;
    logic [W:0] res, exp;
    int lat;
    logic ok;
    op_a = '1;
    op_b = '1;
    op_cin = 1'b0;
    op_sub = 1'b0;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (2 * (HOLD + 1)) tick;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || {add_a, add_b, add_cin} !== '0) begin
      failures++;
      $display("FAIL midrst_ctl in_ready=%b out_valid=%b add_a=%h add_b=%h add_cin=%b required 1/0/0",
               in_ready, out_valid, add_a, add_b, add_cin);
    end
    checks++;
    if ({out_cout, out_sum} !== '0) begin
      failures++;
      $display("FAIL midrst_out out_sum=%h out_cout=%b required 0", out_sum, out_cout);
    end
    tick;
    rst = 1'b0;
    ok = 1'b1;
    repeat (30) begin
      tick;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL midrst_quiet out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    exp = {1'b0, 64'h0, 64'h1, 64'h0, 64'h2};
    do_add({128'h0, {128{1'b1}}}, W'(2), 1'b1, 1'b0, res, lat);
    checks++;
    if (res !== exp || lat != LAT) begin
      failures++;
      $display("FAIL midrst_next got=%h lat=%0d required=%h lat=%0d", res, lat, exp, LAT);
    end
    release_out;
  endtask

`ifdef MWADD_SUB_EN
  task automatic test_sub;
    logic [W:0] res;
    int lat;
    do_add(W'(5), W'(7), 1'b0, 1'b1, res, lat);
    checks++;
    if (res !== {1'b0, {(W-1){1'b1}}, 1'b0}) begin
      failures++;
      $display("FAIL sub_5_7 got=%h required=%h", res, {1'b0, {(W-1){1'b1}}, 1'b0});
    end
    release_out;
    do_add(W'(7), W'(5), 1'b0, 1'b1, res, lat);
    checks++;
    if (res !== {1'b1, W'(2)}) begin
      failures++;
      $display("FAIL sub_7_5 got=%h required=%h", res, {1'b1, W'(2)});
    end
    release_out;
  endtask
`endif

  task automatic test_random;
    logic [W-1:0] a, b;
    logic cin;
    logic [W:0] res, exp;
    int lat;
    for (int n = 0; n < 1000; n++) begin
      a = rnd();
      b = rnd();
      cin = 1'($urandom);
      out_ready = 1'($urandom);
      exp = {1'b0, a} + {1'b0, b} + (W + 1)'(cin);
      do_add(a, b, cin, 1'b0, res, lat);
      checks++;
      if (res !== exp || lat != LAT) begin
        failures++;
        $display("FAIL random[%0d] got=%h lat=%0d required=%h lat=%0d", n, res, lat, exp, LAT);
      end
      if (out_ready) tick;
      else begin
        repeat ($urandom_range(0, 4)) tick;
        release_out;
      end
      out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset;
    test_all_ones;
    test_ripple;
    test_stall;
    test_reset_mid;
`ifdef MWADD_SUB_EN
    test_sub;
`endif
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mwadd_seq.md
MWADD_SEQ -- requirements
Module: mwadd_seq

Interface
REQ-001 SHALL have parameter N_CHUNKS, default 4, number of 64-bit chunks per operand (operand width 64*N_CHUNKS).
REQ-002 SHALL have parameter HOLD, default 2, cycles operands are held before the downstream adder's registered output is valid.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, operand pair offered.
REQ-006 SHALL have port in_ready, output, 1, sequencer can accept operands.
REQ-007 SHALL have ports op_a and op_b, input, 64*N_CHUNKS, wide operands.
REQ-008 SHALL have port op_cin, input, 1, carry-in of the wide add.
REQ-009 SHALL have ports add_a and add_b, output, 64, chunk operands to the 64-bit adder.
REQ-010 SHALL have port add_cin, output, 1, chunk carry-in to the adder.
REQ-011 SHALL have ports add_sum (input, 64) and add_cout (input, 1), registered adder result.
REQ-012 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_sum (output, 64*N_CHUNKS) and out_cout (output, 1).

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-014 SHALL, on in_valid&&in_ready, latch op_a, op_b, op_cin, clear chunk index k and phase counter c, and enter RUN.
REQ-015 SHALL, in RUN, drive add_a/add_b with chunk k of the latched operands (chunk 0 = bits 63:0) and hold them and add_cin constant for all HOLD+1 cycles of the chunk.
REQ-016 SHALL drive add_cin = latched op_cin for k=0 and the captured add_cout of chunk k-1 for k>0.
REQ-017 SHALL, in phase c=HOLD, capture add_sum into out_sum chunk k and add_cout into the carry register, then increment k and reset c to 0.
REQ-018 SHALL, after capturing chunk N_CHUNKS-1, set out_cout to that carry and enter DONE; out_valid rises exactly N_CHUNKS*(HOLD+1) edges after the accept edge (12 at defaults).
REQ-019 SHALL hold out_sum/out_cout stable in DONE until out_valid&&out_ready, then return to IDLE; no input accepted in that same cycle.
REQ-020 SHALL ignore in_valid in RUN and DONE; out_ready outside DONE has no effect.
REQ-021 SHALL drive add_a, add_b, add_cin to 0 in IDLE and DONE.
REQ-022 SHALL produce out_sum/out_cout equal to the full (64*N_CHUNKS+1)-bit sum op_a+op_b+op_cin, wrapping modulo 2^(64*N_CHUNKS) with carry on out_cout.

Reset
REQ-023 SHALL, on rst asserted at any time including mid-RUN, immediately enter IDLE and clear k, c, carry, out_sum, out_cout, latched operands; in_ready=1, out_valid=0, add_* =0.
REQ-024 SHALL discard any partially computed result on reset; no out_valid pulse follows deassertion.

Configuration
REQ-025 SHALL, with MWADD_SUB_EN defined, add input op_sub (1 bit, latched on accept) that, when 1, drives add_b as the bitwise inverse of chunk k of op_b and forces chunk-0 add_cin to 1, computing op_a-op_b (out_cout=1 means no borrow).
REQ-026 SHALL, without MWADD_SUB_EN, have no op_sub port and perform addition only.

Structure
REQ-027 SHALL place the FSM state enum, CHUNK_W=64 and default N_CHUNKS/HOLD constants in package mwadd_pkg.
REQ-028 SHALL implement the k/c counting in sub-module mwadd_chunk_ctr (outputs k, c, last_phase, last_chunk).

Verification
REQ-029 SHALL cover: op_a=all ones, op_b=1, op_cin=0 -> out_sum=0, out_cout=1, out_valid 12 edges after accept.
REQ-030 SHALL cover: op_a=0x...0001_FFFFFFFFFFFFFFFF pattern with op_b=1 -> carry ripples chunk0->chunk1, add_cin=1 observed during chunk 1 only.
REQ-031 SHALL cover: out_ready held 0 for 5 cycles in DONE -> out_sum stable, in_ready=0; release -> IDLE next cycle.
REQ-032 SHALL cover: rst pulsed during chunk 2 -> IDLE, all outputs 0, no subsequent out_valid; next operand pair computes correctly.
REQ-033 SHALL cover (MWADD_SUB_EN): op_a=5, op_b=7, op_sub=1 -> out_sum=2^256-2, out_cout=0; op_a=7, op_b=5 -> out_sum=2, out_cout=1.
REQ-034 SHALL cover: 1000 random operand pairs with random out_ready stalls -> results match 257-bit reference sum.
